// File: rtl/median_filter_ctrl.sv
// Sequencer for the 3x3 bubble-sort median datapath: fetches each pixel's window,
// drives the sorter handshake and writes the median back. Macro REPLICATE_EDGE_EN selects edge replication.
module median_filter_ctrl #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [71:0]       win_data,
    output logic              sort_start,
    input  logic              sort_finish,
    input  logic [7:0]        sort_median,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

`ifdef REPLICATE_EDGE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic signed [RW+1:0] H_S = (RW+2)'(IMG_H);
    localparam logic signed [CW+1:0] W_S = (CW+2)'(IMG_W);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SORT,
        WRITE,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [RW-1:0]     row_reg;
    logic [CW-1:0]     col_reg;
    logic [3:0]        k_reg;
    logic              rd_valid_reg;

    logic signed [1:0]    dr, dc;
    logic signed [RW+1:0] nr;
    logic signed [CW+1:0] nc;
    logic [RW-1:0]        nr_c;
    logic [CW-1:0]        nc_c;
    logic                 in_range;
    logic                 issue;
    logic                 last_pixel;
    logic [ADDR_W-1:0]    nbr_addr;
    logic [ADDR_W-1:0]    pixel_addr;

    // Neighbour offset for window element k: row k/3-1, column k%3-1.
    always_comb begin
        dr = 2'sb01;
        dc = 2'sb01;
        if (k_reg < 4'd3)
            dr = 2'sb11;
        else if (k_reg < 4'd6)
            dr = 2'sb00;
        case (k_reg)
            4'd0, 4'd3, 4'd6: dc = 2'sb11;
            4'd1, 4'd4, 4'd7: dc = 2'sb00;
            default:          dc = 2'sb01;
        endcase
    end

    // Coordinates are widened and signed so that -1 and IMG_W/IMG_H are both detectable.
    always_comb begin
        nr = $signed({2'b00, row_reg}) + $signed({{RW{dr[1]}}, dr});
        nc = $signed({2'b00, col_reg}) + $signed({{CW{dc[1]}}, dc});
        in_range = !nr[RW+1] && (nr < H_S) && !nc[CW+1] && (nc < W_S);

        if (nr[RW+1])
            nr_c = '0;
        else if (nr >= H_S)
            nr_c = RW'(IMG_H - 1);
        else
            nr_c = nr[RW-1:0];

        if (nc[CW+1])
            nc_c = '0;
        else if (nc >= W_S)
            nc_c = CW'(IMG_W - 1);
        else
            nc_c = nc[CW-1:0];

        nbr_addr   = ADDR_W'(nr_c) * ADDR_W'(IMG_W) + ADDR_W'(nc_c);
        pixel_addr = ADDR_W'(row_reg) * ADDR_W'(IMG_W) + ADDR_W'(col_reg);
        last_pixel = (row_reg == RW'(IMG_H - 1)) && (col_reg == CW'(IMG_W - 1));
        issue      = (state_reg == FETCH) && (k_reg < 4'd9) && (REPLICATE || in_range);
    end

    assign rd_en      = issue;
    assign rd_addr    = issue ? nbr_addr : '0;
    assign busy       = (state_reg == FETCH) || (state_reg == LOAD) ||
                        (state_reg == SORT)  || (state_reg == WRITE);
    assign done       = (state_reg == DONE);
    assign wr_en      = (state_reg == WRITE);
    assign sort_start = (state_reg == SORT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (go) state_next = FETCH;
            FETCH:   if (k_reg == 4'd9) state_next = LOAD;
            LOAD:    state_next = SORT;
            SORT:    if (sort_finish) state_next = WRITE;
            WRITE:   state_next = last_pixel ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg      <= '0;
            col_reg      <= '0;
            k_reg        <= '0;
            rd_valid_reg <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            rd_valid_reg <= issue;
            k_reg        <= (state_reg == FETCH && k_reg != 4'd9) ? k_reg + 4'd1 : 4'd0;
            case (state_reg)
                IDLE: begin
                    if (go) begin
                        row_reg <= '0;
                        col_reg <= '0;
                    end
                end
                SORT: begin
                    if (sort_finish) begin
                        wr_data <= sort_median;
                        wr_addr <= pixel_addr;
                    end
                end
                WRITE: begin
                    if (!last_pixel) begin
                        if (col_reg == CW'(IMG_W - 1)) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Element gi arrives from the RAM one cycle after its issue, i.e. while k == gi+1.
    for (genvar gi = 0; gi < 9; gi++) begin : g_win
        logic [7:0] byte_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                byte_reg <= '0;
            else if (state_reg == FETCH && k_reg == 4'(gi + 1))
                byte_reg <= rd_valid_reg ? rd_data : 8'd0;
        end
        assign win_data[71-8*gi -: 8] = byte_reg;
    end

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Self-checking bench for median_filter_ctrl on a 4x4 image with RAM and sorter models;
// expected medians come from a direct neighbourhood sort of the image.
module tb_median_filter_ctrl;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic        clk, rst, go;
    logic        busy, done, rd_en, sort_start, sort_finish, wr_en;
    logic [3:0]  rd_addr, wr_addr;
    logic [7:0]  rd_data, sort_median, wr_data;
    logic [71:0] win_data;

    median_filter_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .win_data(win_data), .sort_start(sort_start),
        .sort_finish(sort_finish), .sort_median(sort_median),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] img     [NPIX];
    logic [7:0] ref_med [NPIX];
    int         exp_rd;
    int         n_checks = 0;
    int         n_fails  = 0;
    int         wr_idx, rd_cnt, done_cnt, excl_err;
    logic       prev_ss = 1'b0;
    logic       prev_fin = 1'b0;
    int         delay_mode = 3;

    // Image RAM: one-cycle read latency.
    always @(posedge clk)
        if (rd_en) rd_data <= img[rd_addr];

    // Sorter model: loads while sort_start=0, raises finish s_delay cycles into iterate.
    logic [71:0] sw_q;
    int          s_cnt, s_delay;
    always @(posedge clk) begin
        if (!sort_start) begin
            sw_q        <= win_data;
            s_cnt       <= 0;
            sort_finish <= 1'b0;
            s_delay     <= (delay_mode == 0) ? int'($urandom_range(1, 20)) : delay_mode;
        end else begin
            s_cnt <= s_cnt + 1;
            if (s_cnt + 1 >= s_delay) sort_finish <= 1'b1;
        end
    end

    function automatic logic [7:0] rank_median(input logic [71:0] w);
        logic [7:0] v [9];
        logic [7:0] m;
        int lt, le;
        m = '0;
        for (int i = 0; i < 9; i++) v[i] = w[71-8*i -: 8];
        for (int i = 0; i < 9; i++) begin
            lt = 0;
            le = 0;
            for (int j = 0; j < 9; j++) begin
                if (v[j] < v[i])  lt++;
                if (v[j] <= v[i]) le++;
            end
            if (lt <= 4 && le >= 5) m = v[i];
        end
        return m;
    endfunction

    assign sort_median = rank_median(sw_q);

    function automatic logic [7:0] ref_median(input int r, input int c);
        int v [9];
        int n, rr, cc, t;
        n = 0;
        for (int a = -1; a <= 1; a++) begin
            for (int b = -1; b <= 1; b++) begin
                rr = r + a;
                cc = c + b;
`ifdef REPLICATE_EDGE_EN
                rr = (rr < 0) ? 0 : (rr >= H) ? H - 1 : rr;
                cc = (cc < 0) ? 0 : (cc >= W) ? W - 1 : cc;
`endif
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) v[n] = int'(img[rr*W+cc]);
                else v[n] = 0;
                n++;
            end
        end
        for (int i = 0; i < 9; i++)
            for (int j = i + 1; j < 9; j++)
                if (v[j] < v[i]) begin t = v[i]; v[i] = v[j]; v[j] = t; end
        return 8'(v[4]);
    endfunction

    task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge and observe every transaction of that cycle.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (rd_en && wr_en) excl_err++;
            if (rd_en) rd_cnt++;
            if (done) done_cnt++;
            if (wr_en) begin
                if (wr_idx < NPIX) begin
                    $display("write %0d: addr=%0d data=%0d", wr_idx, wr_addr, wr_data);
                    check_val("wr_addr", 72'(wr_addr), 72'(wr_idx));
                    check_val("wr_data", 72'(wr_data), 72'(ref_med[wr_idx]));
                end else begin
                    check_val("extra_wr", 72'(wr_idx), 72'(NPIX - 1));
                end
                wr_idx++;
            end
            if (prev_ss && !sort_start) check_val("ss_hold", 72'(prev_fin), 72'(1));
        end
        prev_ss  = sort_start;
        prev_fin = sort_finish;
    endtask

    task automatic load_image(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       img[r*W+c] = 8'd50;
                    1:       img[r*W+c] = 8'(r * 4 + c + 10);
                    default: img[r*W+c] = 8'($urandom_range(0, 255));
                endcase
        exp_rd = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                ref_med[r*W+c] = ref_median(r, c);
                for (int a = -1; a <= 1; a++)
                    for (int b = -1; b <= 1; b++)
`ifdef REPLICATE_EDGE_EN
                        exp_rd++;
`else
                        if (r + a >= 0 && r + a < H && c + b >= 0 && c + b < W) exp_rd++;
`endif
            end
    endtask

    task automatic clear_counts();
        wr_idx   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        excl_err = 0;
    endtask

    task automatic wait_end(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 2000) begin
            tick();
            cyc++;
        end
        if (!done) check_val("pass_timeout", 72'(done), 72'(1));
        tick();
        $display("pass %s: writes=%0d reads=%0d done_pulses=%0d", tag, wr_idx, rd_cnt, done_cnt);
        check_val("wr_count",   72'(wr_idx),   72'(NPIX));
        check_val("done_count", 72'(done_cnt), 72'(1));
        check_val("rd_count",   72'(rd_cnt),   72'(exp_rd));
        check_val("rdwr_excl",  72'(excl_err), 72'(0));
        check_val("busy_off",   72'(busy),     72'(0));
        check_val("done_pulse", 72'(done),     72'(0));
    endtask

    task automatic run_pass(input string tag, input bit hold_go);
        clear_counts();
        go = 1'b1;
        tick();
        check_val("busy_on", 72'(busy), 72'(1));
        if (!hold_go) go = 1'b0;
        wait_end(tag);
        if (hold_go) begin
            clear_counts();
            tick();
            check_val("busy_restart", 72'(busy), 72'(1));
            go = 1'b0;
            wait_end({tag, "_second"});
        end else begin
            tick();
            check_val("idle_stays", 72'(busy), 72'(0));
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        go  = 1'b0;
        clear_counts();
        repeat (3) tick();
        check_val("rst_ctrl", 72'({busy, done, rd_en, wr_en, sort_start}), 72'(0));
        check_val("rst_data", 72'({rd_addr, wr_addr, wr_data}), 72'(0));
        check_val("rst_win",  win_data, 72'(0));
        rst = 1'b0;
        tick();

        load_image(0);
        delay_mode = 3;
        run_pass("flat50", 1'b0);

        load_image(1);
        delay_mode = 20;
        run_pass("ramp", 1'b0);

        load_image(2);
        delay_mode = 0;
        run_pass("random_hold_go", 1'b1);

        // Abort during the sort of pixel 5.
        load_image(2);
        delay_mode = 20;
        clear_counts();
        go = 1'b1;
        tick();
        go = 1'b0;
        cyc = 0;
        while (!(wr_idx == 5 && sort_start) && cyc < 2000) begin
            tick();
            cyc++;
        end
        check_val("reach_sort5", 72'({wr_idx == 5, sort_start}), 72'(3));
        #1 rst = 1'b1;
        #1;
        $display("reset asserted after %0d writes", wr_idx);
        check_val("abort_ctrl", 72'({busy, done, rd_en, wr_en, sort_start}), 72'(0));
        check_val("abort_data", 72'({rd_addr, wr_addr, wr_data}), 72'(0));
        check_val("abort_win",  win_data, 72'(0));
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        check_val("no_wr_after_abort", 72'(wr_idx), 72'(5));
        check_val("idle_after_abort",  72'(busy),   72'(0));

        load_image(2);
        delay_mode = 3;
        run_pass("after_abort", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
